// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC and instruction-memory requests, returns fetched instructions.
// Redirects that occur while a request is still outstanding are handled by draining that request.
module fetch_sequencer #(
    parameter logic [71:0] RESET_PC = 72'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [54:0] branch_addr,
    input  logic        jump,
    input  logic [67:0] jump_addr,
    output logic        imem_req,
    output logic [71:0] imem_addr,
    input  logic        imem_ack,
    input  logic [59:0] imem_data,
    output logic [71:0] pc,
    output logic        inst_valid,
    output logic [59:0] inst,
    output logic [71:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [71:0] pc_nxt;
    logic [71:0] req_addr;
    logic [71:0] req_addr_nxt;
    logic [71:0] target;
    logic        redirect;
    logic        capture;

    assign redirect = jump | branch;
    assign target   = jump ? {4'h0, jump_addr} : {17'h0, branch_addr};

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        imem_req     = 1'b0;
        imem_addr    = pc;
        capture      = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) pc_nxt = target;
            end
            FETCH: begin
                imem_req = !stall;
                if (redirect) begin
                    pc_nxt = target;
                    // Request in flight: keep presenting the old address until it completes
                    if (imem_req && !imem_ack) begin
                        state_nxt    = DRAIN;
                        req_addr_nxt = pc;
                    end
                end else if (imem_req && imem_ack) begin
                    capture = 1'b1;
                    pc_nxt  = pc + 72'd1;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (imem_ack) state_nxt = FETCH;
                if (redirect) pc_nxt = target;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= 60'h0;
            inst_pc    <= 72'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            req_addr   <= req_addr_nxt;
            inst_valid <= capture;
            if (capture) begin
                inst    <= imem_data;
                inst_pc <= pc;
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 72'h0, the PC value loaded on reset.
REQ-002 The block SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL provide port stall, input, 1 bit: hold the PC and suppress new fetch requests.
REQ-005 The block SHALL provide port branch, input, 1 bit: redirect to branch_addr.
REQ-006 The block SHALL provide port branch_addr, input, 55 bits: branch target, zero-extended to 72 bits.
REQ-007 The block SHALL provide port jump, input, 1 bit: redirect to jump_addr.
REQ-008 The block SHALL provide port jump_addr, input, 68 bits: jump target, zero-extended to 72 bits.
REQ-009 The block SHALL provide port imem_req, output, 1 bit: instruction-memory request valid.
REQ-010 The block SHALL provide port imem_addr, output, 72 bits: address of the outstanding request.
REQ-011 The block SHALL provide port imem_ack, input, 1 bit: memory accepts and returns data this cycle; valid only while imem_req=1.
REQ-012 The block SHALL provide port imem_data, input, 60 bits: instruction word, valid with imem_ack.
REQ-013 The block SHALL provide port pc, output, 72 bits: current architectural PC, registered.
REQ-014 The block SHALL provide port inst_valid, output, 1 bit: one-cycle pulse when inst/inst_pc hold a new instruction.
REQ-015 The block SHALL provide port inst, output, 60 bits: fetched instruction, registered.
REQ-016 The block SHALL provide port inst_pc, output, 72 bits: address inst was fetched from, registered.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH and DRAIN, encoded in 2 bits.
REQ-018 IDLE SHALL drive imem_req=0 and transition unconditionally to FETCH on the next cycle.
REQ-019 In FETCH, imem_req SHALL equal !stall and imem_addr SHALL equal pc.
REQ-020 A FETCH-state handshake (imem_req & imem_ack) with no redirect SHALL produce, next cycle, inst=imem_data, inst_pc=old pc, inst_valid=1 and pc=pc+1.
REQ-021 Fetch latency SHALL be one cycle from handshake to inst_valid; back-to-back acks SHALL yield one instruction per cycle.
REQ-022 inst_valid SHALL be 0 in any cycle not following a valid handshake; inst and inst_pc SHALL otherwise hold their last value.
REQ-023 PC increment SHALL be modulo 2^72: 72'hFFFF_FFFF_FFFF_FFFF_FF + 1 -> 72'h0, with no flag.
REQ-024 Redirect SHALL occur when jump|branch=1; jump SHALL take priority over branch when both are asserted.
REQ-025 Redirect SHALL load pc with the zero-extended target next cycle, regardless of stall.
REQ-026 A redirect in FETCH coinciding with imem_ack SHALL discard that data (inst_valid=0) and remain in FETCH.
REQ-027 A redirect in FETCH with imem_req=1 and no imem_ack SHALL move the FSM to DRAIN.
REQ-028 A redirect in FETCH with imem_req=0 (stalled) SHALL load pc and remain in FETCH.
REQ-029 DRAIN SHALL hold imem_req=1 and imem_addr at the pre-redirect address in a separate request-address register, ignoring stall, until imem_ack.
REQ-030 The ack in DRAIN SHALL be discarded (inst_valid=0), and the FSM SHALL return to FETCH.
REQ-031 A further redirect in DRAIN SHALL overwrite pc with the newest target and leave the FSM in DRAIN.
REQ-032 In FETCH, stall=1 without redirect SHALL leave pc unchanged, drive imem_req=0 and inst_valid=0.
REQ-033 imem_ack received while imem_req=0 SHALL be ignored.

Reset
REQ-034 While rst=1, next cycle state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=60'h0, inst_pc=72'h0.
REQ-035 rst SHALL override stall, branch, jump and imem_ack in the same cycle.
REQ-036 Reset asserted in DRAIN or mid-handshake SHALL abandon the request with no inst_valid produced.
REQ-037 First imem_req SHALL assert two cycles after rst deasserts (IDLE, then FETCH).

Verification
REQ-038 A bench SHALL cover reset then imem_ack held high: imem_addr 0,1,2,3 on consecutive cycles; inst_valid continuous from cycle 3; inst_pc trails imem_addr by one cycle.
REQ-039 A bench SHALL cover ack at addr 5 with branch=1, branch_addr=55'h11: no inst_valid for addr 5; next imem_addr=72'h11.
REQ-040 A bench SHALL cover branch=1, branch_addr=55'h20 and jump=1, jump_addr=68'h40 in the same cycle: pc=72'h40.
REQ-041 A bench SHALL cover jump to 68'h100 while ack is withheld 3 cycles at addr 7: imem_addr stays 7 with req=1, pc=72'h100, ack dropped, then the next request is at 72'h100.
REQ-042 A bench SHALL cover stall=1 for 4 cycles at pc=72'h30 with ack=1: imem_req=0, pc=72'h30, inst_valid=0; fetch resumes at 72'h30 after release.
REQ-043 A bench SHALL cover RESET_PC=72'hFF_FFFF_FFFF_FFFF_FFFF with ack held: inst_pc sequence FF..FF then 72'h0.
